// File: rtl/disp_scan_pkg.sv
// Shared types and constants for the display scan controller.
package disp_scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = 3;
    localparam int DUTY_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/disp_scan_ctrl_next_sel.sv
// scan_next_sel: rotate-priority encoder. Finds the first set bit of mask
// searching upward from cur+1 (mod NUM_DIGITS). With cur = NUM_DIGITS-1 it
// returns the lowest set bit.
module scan_next_sel
    import disp_scan_pkg::*;
(
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic [SEL_W-1:0]      cur,
    output logic [SEL_W-1:0]      nxt,
    output logic                  wrap,
    output logic                  none
);

    logic                 found;
    logic [SEL_W-1:0]     idx;

    // Walk positions cur+1 .. cur+NUM_DIGITS; the last one is cur itself,
    // so a single-bit mask returns its own position and reports a wrap.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_DIGITS; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        none = ~found;
        wrap = found && (nxt <= cur);
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: steps a 3-to-8 decoder select through the enabled digits
// of a multiplexed display, with a blanking gap at every digit change.
// Optional macro SCAN_DIM_EN adds a 4-bit duty input for per-digit dimming.
module disp_scan_ctrl
    import disp_scan_pkg::*;
#(
    parameter int CLK_DIV      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [NUM_DIGITS-1:0] digit_mask,
`ifdef SCAN_DIM_EN
    input  logic [DUTY_W-1:0]     duty,
`endif
    output logic [SEL_W-1:0]      sel,
    output logic                  dec_en,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam scan_state_t ENTRY = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_d;
    logic             dec_en_d;
    logic             frame_done_d;

    logic [SEL_W-1:0] search_cur;
    logic [SEL_W-1:0] nxt_sel;
    logic             wrap;
    logic             none;

`ifdef SCAN_DIM_EN
    localparam int SLOT_LEN = CLK_DIV / 16;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]  slot_d;
    logic              show_entry;
`endif

    // In IDLE the search starts from the top so the encoder yields the lowest set bit.
    assign search_cur = (state_q == IDLE) ? SEL_W'(NUM_DIGITS - 1) : sel;
    assign busy       = (state_q != IDLE);

    scan_next_sel u_next_sel (
        .mask (digit_mask),
        .cur  (search_cur),
        .nxt  (nxt_sel),
        .wrap (wrap),
        .none (none)
    );

    // Next-state, counter, select and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel;
        frame_done_d = 1'b0;
        dec_en_d     = 1'b0;
`ifdef SCAN_DIM_EN
        duty_d       = duty_q;
        slot_d       = '0;
        show_entry   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (run && !none) begin
                    state_d = ENTRY;
                    cnt_d   = '0;
                    sel_d   = nxt_sel;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    if (!run || none) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = ENTRY;
                        sel_d        = nxt_sel;
                        frame_done_d = wrap;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef SCAN_DIM_EN
        // A SHOW entry is either arriving from another state or restarting
        // SHOW at a boundary when there is no blanking gap.
        show_entry = (state_d == SHOW) &&
                     ((state_q != SHOW) || (cnt_q == SHOW_LAST));
        if (show_entry) begin
            duty_d = duty;
        end
        slot_d   = cnt_d / CNT_W'(SLOT_LEN);
        dec_en_d = (state_d == SHOW) && (slot_d <= CNT_W'(duty_d));
`else
        dec_en_d = (state_d == SHOW);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel        <= '0;
            dec_en     <= 1'b0;
            frame_done <= 1'b0;
`ifdef SCAN_DIM_EN
            duty_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel        <= sel_d;
            dec_en     <= dec_en_d;
            frame_done <= frame_done_d;
`ifdef SCAN_DIM_EN
            duty_q     <= duty_d;
`endif
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Testbench for disp_scan_ctrl. Expected outputs come from a digit-schedule
// model: each sampled boundary plans a whole digit (blank then show) as a
// queue of per-clock output values.
module tb_disp_scan_ctrl;
    import disp_scan_pkg::*;

`ifdef SCAN_DIM_EN
    localparam int CLK_DIV = 32;
`else
    localparam int CLK_DIV = 4;
`endif
    localparam int BLANK_CYCLES = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic [7:0] digit_mask = '0;
    logic [2:0] sel;
    logic       dec_en, frame_done, busy;
`ifdef SCAN_DIM_EN
    logic [3:0] duty = 4'd3;
`endif

    disp_scan_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .digit_mask (digit_mask),
`ifdef SCAN_DIM_EN
        .duty       (duty),
`endif
        .sel        (sel),
        .dec_en     (dec_en),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic       fd;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_sel = 0;
    bit   m_active = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Next enabled digit strictly above cur, else the lowest one (wrap).
    function automatic int next_bit(input logic [7:0] m, input int cur, output bit wrapped);
        int lowest = -1;
        int higher = -1;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) begin
                if (lowest < 0) lowest = b;
                if (higher < 0 && b > cur) higher = b;
            end
        end
        wrapped = (higher < 0);
        return (higher >= 0) ? higher : lowest;
    endfunction

    function automatic bit show_on(input int j);
`ifdef SCAN_DIM_EN
        return (j / (CLK_DIV / 16)) <= int'(duty);
`else
        return (j >= 0);
`endif
    endfunction

    task automatic plan_digit(input int s, input bit fd);
        exp_t e;
        for (int b = 0; b < BLANK_CYCLES; b++) begin
            e = '{sel: 3'(s), en: 1'b0, fd: fd && (b == 0), busy: 1'b1};
            q.push_back(e);
        end
        for (int j = 0; j < CLK_DIV; j++) begin
            e = '{sel: 3'(s), en: show_on(j), fd: fd && (BLANK_CYCLES == 0) && (j == 0), busy: 1'b1};
            q.push_back(e);
        end
    endtask

    // Inputs are only consulted when the current plan has run out: that is
    // exactly the idle clocks and the digit boundaries.
    task automatic plan();
        bit   w;
        int   n;
        exp_t e;
        if (q.size() != 0) return;
        if (run && digit_mask != 0) begin
            n = next_bit(digit_mask, m_active ? m_sel : -1, w);
            plan_digit(n, m_active && w);
            m_sel    = n;
            m_active = 1'b1;
        end else begin
            e = '{sel: 3'(m_sel), en: 1'b0, fd: 1'b0, busy: 1'b0};
            q.push_back(e);
            m_active = 1'b0;
        end
    endtask

    task automatic step();
        exp_t e;
        plan();
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("sel", 8'(sel), 8'(e.sel));
        chk("dec_en", 8'(dec_en), 8'(e.en));
        chk("frame_done", 8'(frame_done), 8'(e.fd));
        chk("busy", 8'(busy), 8'(e.busy));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_reset();
        q.delete();
        m_sel    = 0;
        m_active = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sel"}, 8'(sel), 8'd0);
        chk({tag, "_dec_en"}, 8'(dec_en), 8'd0);
        chk({tag, "_frame_done"}, 8'(frame_done), 8'd0);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
    endtask

    localparam int PERIOD = CLK_DIV + BLANK_CYCLES;

    initial begin
        // Reset held across clock edges.
        #1 rst_n = 1'b0;
        #3 chk_zero("reset");
        run        = 1'b1;
        digit_mask = 8'hFF;
        @(posedge clk); #1 chk_zero("reset_hold");
        @(posedge clk); #1 chk_zero("reset_hold2");
        run   = 1'b0;
        rst_n = 1'b1;
        model_reset();
        steps(3);

        // Full mask, two full frames.
        digit_mask = 8'hFF;
        run        = 1'b1;
        steps(8 * PERIOD * 2 + 3);

        // Sparse mask, change lands mid-digit.
        digit_mask = 8'b1010_0100;
        steps(4 * PERIOD * 2);

        // Single digit, then empty mask.
        digit_mask = 8'h10;
        steps(4 * PERIOD + 2);
        digit_mask = 8'h00;
        steps(PERIOD + 6);

        // Stop two clocks into SHOW (idle -> blank -> show -> show).
        digit_mask = 8'hFF;
        run        = 1'b1;
        steps(BLANK_CYCLES + 2);
        run = 1'b0;
        steps(CLK_DIV + 4);

        // Asynchronous reset during SHOW, then restart at the lowest digit.
        digit_mask = 8'b0110_0000;
        run        = 1'b1;
        steps(BLANK_CYCLES + 2);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        @(posedge clk); #1 chk_zero("async_rst_hold");
        rst_n = 1'b1;
        model_reset();
        steps(3 * PERIOD + 2);

        // Randomized masks and run toggles, changes at arbitrary clocks.
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 4))
                0:       digit_mask = 8'hFF;
                1:       digit_mask = 8'(1 << $urandom_range(0, 7));
                2:       digit_mask = 8'h00;
                default: digit_mask = 8'($urandom);
            endcase
            run = ($urandom_range(0, 5) != 0);
            steps($urandom_range(1, 3 * PERIOD));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Sequencer for the 3-to-8 decoder (inputs `a[2:0]` and `en`, one-hot output `y[7:0]`).
- Steps the decoder select through the enabled digit positions of an 8-digit multiplexed display.
- Inserts a blanking gap at every digit change so no position is ever lit with a stale select.
- Sits between the display data path and the decoder. `sel` drives `a`, `dec_en` drives `en`.

Parameters:
- CLK_DIV, default 16: clocks each digit is shown (SHOW length). Must be ≥1; with SCAN_DIM_EN it must be ≥16 and a multiple of 16.
- BLANK_CYCLES, default 2: clocks `dec_en` is held low between digits. 0 is legal and removes BLANK.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: scan enable, level-sensitive.
- `digit_mask` in 8: bit i=1 means decoder output i is included in the scan.
- `sel` out 3: decoder select. Registered; wire to decoder `a`.
- `dec_en` out 1: decoder enable. Registered; wire to decoder `en`.
- `frame_done` out 1: one-clock pulse when the scan wraps back to the lowest enabled digit.
- `busy` out 1: high whenever state ≠ IDLE.

Behaviour:
- Reset (async, `rst_n`=0): `sel`=0, `dec_en`=0, `frame_done`=0, `busy`=0, state=IDLE, counter=0. All of these hold for as long as `rst_n` is low.
- States:
  - IDLE: `dec_en`=0.
  - BLANK: `dec_en`=0; counter runs to BLANK_CYCLES.
  - SHOW: `dec_en`=1; counter runs to CLK_DIV.
- IDLE → BLANK (or → SHOW if BLANK_CYCLES=0): taken when `run`=1 and `digit_mask`≠0.
  - On that edge, `sel` loads the lowest set bit index of `digit_mask`.
- BLANK → SHOW: after exactly BLANK_CYCLES clocks in BLANK. `sel` is stable throughout BLANK.
- SHOW end (after exactly CLK_DIV clocks with `dec_en`=1): the digit boundary. `run` and `digit_mask` are sampled only here and at IDLE exit.
  - If `run`=0 or `digit_mask`=0: go to IDLE. `dec_en` falls on the same edge; `sel` holds its last value.
  - Otherwise: `sel` takes the next set bit in `digit_mask`, searching upward from `sel`+1 modulo 8, then go to BLANK (or SHOW if BLANK_CYCLES=0).
  - If the new `sel` ≤ old `sel` (wrap), `frame_done`=1 for that one clock.
- Single-bit mask: `sel` is unchanged at every boundary and `frame_done` pulses at every boundary.
- Stop behaviour: deasserting `run` mid-digit completes the current SHOW first, so there is no truncated digit. A mask change mid-digit takes effect at the next boundary.
- `sel` changes only while `dec_en`=0 or on the SHOW-exit edge, where `dec_en` goes low on the same edge. With BLANK_CYCLES=0, `sel` may change while `dec_en` stays high.
- Steady-state period per digit is CLK_DIV + BLANK_CYCLES clocks. Latency from `run` rising in IDLE to first `dec_en`=1 is BLANK_CYCLES+1 clocks.
- Counter width is `$clog2(max(CLK_DIV, BLANK_CYCLES)+1)`. It resets to 0 on every state entry.

Optional Feature:
- Macro: SCAN_DIM_EN.
- Defined:
  - Adds input `duty` [3:0], sampled at every SHOW entry.
  - SHOW is split into 16 slots of CLK_DIV/16 clocks each.
  - `dec_en`=1 only while slot index ≤ `duty`.
  - `duty`=15 gives full on-time; `duty`=0 gives 1/16.
  - SHOW length, and therefore scan timing and `frame_done`, is unchanged.
- Undefined: no `duty` port; `dec_en`=1 for all of SHOW.

Decomposition:
- Package `disp_scan_pkg`:
  - NUM_DIGITS=8, SEL_W=3.
  - State enum typedef `scan_state_t` {IDLE, BLANK, SHOW}.
  - DUTY_W=4.
- Sub-module `scan_next_sel`: combinational rotate-priority encoder.
  - Inputs: `mask[7:0]`, `cur[2:0]`.
  - Outputs: `nxt[2:0]`, `wrap`, `none`.
  - Reused for the IDLE-exit search (lowest set bit) and the boundary search (next set bit after `cur`).

Test Plan (CLK_DIV=4, BLANK_CYCLES=1 unless noted):
1. Full mask, basic scan: `rst_n` low then high, `digit_mask`=8'hFF, `run`=1 → `sel` steps 0,1,…,7,0. Each digit has 1 clock `dec_en`=0 then 4 clocks `dec_en`=1. `frame_done` pulses once at the 7→0 wrap, every 40 clocks.
2. Sparse mask: `digit_mask`=8'b1010_0100 → `sel` sequence 2,5,7,2. No `dec_en` high at 0,1,3,4,6. `frame_done` pulses at the 7→2 wrap.
3. Single-bit mask and empty mask:
   - `digit_mask`=8'h10 → `sel` constant 4, `frame_done` pulse every 5 clocks.
   - `digit_mask`=0 with `run`=1 → stays IDLE, `dec_en`=0, `busy`=0.
4. Stop mid-digit: drop `run` 2 clocks into SHOW → `dec_en` stays high 2 more clocks, then 0; `busy` falls on the same edge.
5. Async reset during SHOW: assert `rst_n`=0 asynchronously → `dec_en`, `sel`, `frame_done` go to 0 immediately without a clock edge. After release with `run`=1, scan restarts at the lowest set bit.
6. SCAN_DIM_EN, CLK_DIV=32, `duty`=3 → `dec_en` high for exactly 8 of 32 SHOW clocks per digit. Per-digit period unchanged at 33 clocks.
